mem_port_arbiter: RTL and testbench

//  Shares one single-port, fixed-latency memory between the IF stage (instruction fetch) and the MEM stage (load/store).

---
 rtl/mem_port_arbiter.sv | 144 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port, fixed-latency memory between instruction fetch and
// load/store. Data has fixed priority. Hold stalls the pipeline until every request of the round is served.
module mem_port_arbiter #(
  parameter int AW      = 8,
  parameter int DW      = 32,
  parameter int MEM_LAT = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_ready,
  output logic [DW-1:0] if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ready,
  output logic [DW-1:0] d_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          hold
);

  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  typedef enum logic [1:0] {IDLE, BUSY_D, BUSY_I, RESP} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic          gnt_d_q;
  logic [AW-1:0] addr_q;
  logic          we_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] if_rdata_q, d_rdata_q;
  logic          if_done_q, d_done_q;
  logic          elig_d, elig_i;

  assign elig_d = d_req & ~d_done_q;
  assign elig_i = if_req & ~if_done_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:          if (elig_d) state_d = BUSY_D;
                     else if (elig_i) state_d = BUSY_I;
      BUSY_D, BUSY_I: if (cnt_q == '0) state_d = RESP;
      RESP:          state_d = IDLE;
      default:       state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if_ready  = 1'b0;
    d_ready   = 1'b0;
    case (state_q)
      BUSY_D: begin
        mem_en    = 1'b1;
        mem_we    = we_q;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
      end
      BUSY_I: begin
        mem_en   = 1'b1;
        mem_addr = addr_q;
      end
      RESP: begin
        if_ready = ~gnt_d_q;
        d_ready  = gnt_d_q;
      end
      default: ;
    endcase
  end

  assign hold     = (if_req & ~if_done_q & ~if_ready) | (d_req & ~d_done_q & ~d_ready);
  assign if_rdata = if_rdata_q;
  assign d_rdata  = d_rdata_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q      <= '0;
      gnt_d_q    <= 1'b0;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (elig_d) begin
            gnt_d_q <= 1'b1;
            addr_q  <= d_addr;
            we_q    <= d_we;
            wdata_q <= d_wdata;
            cnt_q   <= CW'(MEM_LAT - 1);
          end else if (elig_i) begin
            gnt_d_q <= 1'b0;
            addr_q  <= if_addr;
            we_q    <= 1'b0;
            wdata_q <= '0;
            cnt_q   <= CW'(MEM_LAT - 1);
          end
        end
        BUSY_D, BUSY_I: begin
          if (cnt_q == '0) begin
            if (state_q == BUSY_I)  if_rdata_q <= mem_rdata;
            else if (!we_q)         d_rdata_q  <= mem_rdata;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Round end beats the RESP set so a request still held high is served again.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      if_done_q <= 1'b0;
      d_done_q  <= 1'b0;
    end else if (!hold) begin
      if_done_q <= 1'b0;
      d_done_q  <= 1'b0;
    end else if (state_q == RESP) begin
      if (gnt_d_q) d_done_q  <= 1'b1;
      else         if_done_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: cycle vector table plus hand-written
// sequences for mid-access reset and continuous fetch.
module tb_mem_port_arbiter;
  localparam int AW = 8, DW = 32, MEM_LAT = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          if_req, d_req, d_we;
  logic [AW-1:0] if_addr, d_addr;
  logic [DW-1:0] d_wdata;
  logic          if_ready, d_ready, mem_en, mem_we, hold;
  logic [DW-1:0] if_rdata, d_rdata, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;

  int nchk = 0;
  int nerr = 0;

  mem_port_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(MEM_LAT)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(d_ready), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .hold(hold)
  );

  always #5 clk = ~clk;

  // Memory model: word a holds A50000aa, except word 4.
  logic [DW-1:0] mem [256];
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'hA500_0000 | i;
    mem[4] = 32'h2001_0005;
  end
  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;

  typedef struct {
    logic          ifq;
    logic [AW-1:0] ifa;
    logic          dq, dwe;
    logic [AW-1:0] da;
    logic [DW-1:0] dwd;
    logic          e_en, e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wd;
    logic          e_ifr, e_dr, e_hold;
    logic [DW-1:0] e_ifd, e_dd;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic ifq, logic [AW-1:0] ifa, logic dq, logic dwe,
                              logic [AW-1:0] da, logic [DW-1:0] dwd,
                              logic e_en, logic e_we, logic [AW-1:0] e_addr, logic [DW-1:0] e_wd,
                              logic e_ifr, logic e_dr, logic e_hold,
                              logic [DW-1:0] e_ifd, logic [DW-1:0] e_dd);
    vec_t v;
    v.ifq = ifq; v.ifa = ifa; v.dq = dq; v.dwe = dwe; v.da = da; v.dwd = dwd;
    v.e_en = e_en; v.e_we = e_we; v.e_addr = e_addr; v.e_wd = e_wd;
    v.e_ifr = e_ifr; v.e_dr = e_dr; v.e_hold = e_hold; v.e_ifd = e_ifd; v.e_dd = e_dd;
    return v;
  endfunction

  task automatic chk(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(vec_t v, int idx);
    if_req = v.ifq; if_addr = v.ifa; d_req = v.dq; d_we = v.dwe; d_addr = v.da; d_wdata = v.dwd;
    #3;
    chk($sformatf("v%0d mem_en", idx), 32'(mem_en), 32'(v.e_en));
    chk($sformatf("v%0d mem_we", idx), 32'(mem_we), 32'(v.e_we));
    if (v.e_en) chk($sformatf("v%0d mem_addr", idx), 32'(mem_addr), 32'(v.e_addr));
    if (v.e_we) chk($sformatf("v%0d mem_wdata", idx), mem_wdata, v.e_wd);
    chk($sformatf("v%0d if_ready", idx), 32'(if_ready), 32'(v.e_ifr));
    chk($sformatf("v%0d d_ready", idx), 32'(d_ready), 32'(v.e_dr));
    chk($sformatf("v%0d hold", idx), 32'(hold), 32'(v.e_hold));
    chk($sformatf("v%0d if_rdata", idx), if_rdata, v.e_ifd);
    chk($sformatf("v%0d d_rdata", idx), d_rdata, v.e_dd);
    next_cycle();
  endtask

  localparam logic [DW-1:0] F4  = 32'h2001_0005;
  localparam logic [DW-1:0] M08 = 32'hA500_0008;
  localparam logic [DW-1:0] M10 = 32'hA500_0010;
  localparam logic [DW-1:0] M30 = 32'hA500_0030;
  localparam logic [DW-1:0] DB  = 32'hDEAD_BEEF;

  initial begin
    reset = 1'b0; if_req = 0; if_addr = '0; d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;

    // idle after reset
    vecs.push_back(mk(0,8'h00,0,0,8'h00,0, 0,0,8'h00,0, 0,0,0, 0,0));
    vecs.push_back(mk(0,8'h00,0,0,8'h00,0, 0,0,8'h00,0, 0,0,0, 0,0));
    vecs.push_back(mk(0,8'h00,0,0,8'h00,0, 0,0,8'h00,0, 0,0,0, 0,0));
    // single fetch from 0x04
    vecs.push_back(mk(1,8'h04,0,0,8'h00,0, 0,0,8'h00,0, 0,0,1, 0,0));
    vecs.push_back(mk(1,8'h04,0,0,8'h00,0, 1,0,8'h04,0, 0,0,1, 0,0));
    vecs.push_back(mk(1,8'h04,0,0,8'h00,0, 1,0,8'h04,0, 0,0,1, 0,0));
    vecs.push_back(mk(1,8'h04,0,0,8'h00,0, 0,0,8'h00,0, 1,0,0, F4,0));
    vecs.push_back(mk(0,8'h00,0,0,8'h00,0, 0,0,8'h00,0, 0,0,0, F4,0));
    // simultaneous fetch 0x08 and load 0x10: load first
    vecs.push_back(mk(1,8'h08,1,0,8'h10,0, 0,0,8'h00,0, 0,0,1, F4,0));
    vecs.push_back(mk(1,8'h08,1,0,8'h10,0, 1,0,8'h10,0, 0,0,1, F4,0));
    vecs.push_back(mk(1,8'h08,1,0,8'h10,0, 1,0,8'h10,0, 0,0,1, F4,0));
    vecs.push_back(mk(1,8'h08,1,0,8'h10,0, 0,0,8'h00,0, 0,1,1, F4,M10));
    vecs.push_back(mk(1,8'h08,1,0,8'h10,0, 0,0,8'h00,0, 0,0,1, F4,M10));
    vecs.push_back(mk(1,8'h08,1,0,8'h10,0, 1,0,8'h08,0, 0,0,1, F4,M10));
    vecs.push_back(mk(1,8'h08,1,0,8'h10,0, 1,0,8'h08,0, 0,0,1, F4,M10));
    vecs.push_back(mk(1,8'h08,1,0,8'h10,0, 0,0,8'h00,0, 1,0,0, M08,M10));
    vecs.push_back(mk(0,8'h00,0,0,8'h00,0, 0,0,8'h00,0, 0,0,0, M08,M10));
    // store to 0x20: d_rdata untouched
    vecs.push_back(mk(0,8'h00,1,1,8'h20,DB, 0,0,8'h00,0, 0,0,1, M08,M10));
    vecs.push_back(mk(0,8'h00,1,1,8'h20,DB, 1,1,8'h20,DB, 0,0,1, M08,M10));
    vecs.push_back(mk(0,8'h00,1,1,8'h20,DB, 1,1,8'h20,DB, 0,0,1, M08,M10));
    vecs.push_back(mk(0,8'h00,1,1,8'h20,DB, 0,0,8'h00,0, 0,1,0, M08,M10));
    vecs.push_back(mk(0,8'h00,0,0,8'h00,0, 0,0,8'h00,0, 0,0,0, M08,M10));

    // reset state
    #3;
    chk("rst mem_en", 32'(mem_en), 0);
    chk("rst hold", 32'(hold), 0);
    chk("rst if_ready", 32'(if_ready), 0);
    chk("rst d_ready", 32'(d_ready), 0);
    chk("rst if_rdata", if_rdata, 0);
    chk("rst d_rdata", d_rdata, 0);
    next_cycle();
    reset = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i], i);
    chk("store landed", mem[8'h20], DB);

    // reset in cycle 1 of a fetch, then full new access after release
    if_req = 1; if_addr = 8'h04;
    next_cycle();
    chk("rst5 busy before", 32'(mem_en), 1);
    reset = 1'b0;
    #1;
    chk("rst5 mem_en async", 32'(mem_en), 0);
    for (int k = 0; k < 3; k++) begin
      #2;
      chk($sformatf("rst5 no ready %0d", k), 32'(if_ready), 0);
      chk($sformatf("rst5 no mem_en %0d", k), 32'(mem_en), 0);
      next_cycle();
    end
    reset = 1'b1;
    for (int k = 0; k <= MEM_LAT + 1; k++) begin
      #3;
      chk($sformatf("rst5 c%0d if_ready", k), 32'(if_ready), 32'(k == MEM_LAT + 1));
      chk($sformatf("rst5 c%0d mem_en", k), 32'(mem_en), 32'(k >= 1 && k <= MEM_LAT));
      next_cycle();
    end
    chk("rst5 if_rdata", if_rdata, F4);
    if_req = 0;
    next_cycle();

    // continuous fetch: ready every MEM_LAT+2 cycles
    if_req = 1; if_addr = 8'h30;
    for (int k = 0; k < 12; k++) begin
      #3;
      chk($sformatf("cont c%0d if_ready", k), 32'(if_ready), 32'(k % 4 == 3));
      chk($sformatf("cont c%0d hold", k), 32'(hold), 32'(k % 4 != 3));
      chk($sformatf("cont c%0d mem_en", k), 32'(mem_en), 32'(k % 4 == 1 || k % 4 == 2));
      if (k % 4 == 3) chk($sformatf("cont c%0d if_rdata", k), if_rdata, M30);
      next_cycle();
    end
    if_req = 0;
    next_cycle();

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
